// File: rtl/lr_shift_pipe_pkg.sv
// Shared types and helpers for the pipelined left/right shifter.
// Mode encoding is fixed because upstream units drive it as raw bits.
package lr_shift_pipe_pkg;

    typedef enum logic [2:0] {
        SHIFT_LEFT          = 3'd0,
        SHIFT_RIGHT_LOGICAL = 3'd1,
        SHIFT_RIGHT_ARITH   = 3'd2,
        ROTATE_LEFT         = 3'd3,
        ROTATE_RIGHT        = 3'd4
    } shift_mode_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lr_shift_pipe_if.sv
// Streaming source (word + shift request) and result channels of the shifter.
// The slave modport is the shifter's view; master is the surrounding datapath.
interface lr_shift_pipe_if #(parameter int width = 8);
    import lr_shift_pipe_pkg::*;

    localparam int SW = clog2(width);

    logic [width-1:0] src_bits;
    logic [SW-1:0]    src_shift;
    shift_mode_e      src_mode;
    logic             src_valid;
    logic             src_ready;

    logic [width-1:0] res_bits;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output src_bits, src_shift, src_mode, src_valid, res_ready,
        input  src_ready, res_bits, res_valid
    );

    modport slave (
        input  src_bits, src_shift, src_mode, src_valid, res_ready,
        output src_ready, res_bits, res_valid
    );

endinterface

// File: rtl/lr_shift_pipe_stage.sv
// One barrel stage: conditional shift/rotate by 2**k, then an enable-gated register
// carrying data, mode, the full shift request and valid.
module lr_shift_stage
    import lr_shift_pipe_pkg::*;
#(
    parameter int width = 8,
    parameter int k     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     advance,
    input  logic [width-1:0]         data,
    input  logic [clog2(width)-1:0]  shift,
    input  logic [2:0]               mode,
    input  logic                     valid,
    output logic [width-1:0]         data_q,
    output logic [clog2(width)-1:0]  shift_q,
    output logic [2:0]               mode_q,
    output logic                     valid_q
);

    localparam int DIST = 2 ** k;
    // Rotations compose modulo width, so s >= width in rotate modes needs no special case.
    localparam int ROT  = DIST % width;

    logic [width-1:0] moved;

    always_comb begin
        moved = data << DIST;
        case (shift_mode_e'(mode))
            SHIFT_RIGHT_LOGICAL: moved = data >> DIST;
            SHIFT_RIGHT_ARITH:   moved = $signed(data) >>> DIST;
            ROTATE_LEFT:         moved = (data << ROT) | (data >> (width - ROT));
            ROTATE_RIGHT:        moved = (data >> ROT) | (data << (width - ROT));
            default:             ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            shift_q <= '0;
            mode_q  <= '0;
            valid_q <= 1'b0;
        end else if (advance) begin
            data_q  <= shift[k] ? moved : data;
            shift_q <= shift;
            mode_q  <= mode;
            valid_q <= valid;
        end
    end

endmodule

// File: rtl/lr_shift_pipe.sv
// Pipelined shifter: one barrel stage per shift-amount bit plus a result register,
// with a single global stall driven by the registered result handshake.
module lr_shift_pipe
    import lr_shift_pipe_pkg::*;
#(
    parameter int width = 8
) (
    input  logic           clk,
    input  logic           rst,
    lr_shift_pipe_if.slave bus
);

    localparam int SW = clog2(width);

    logic                  stall;
    logic                  advance;
    logic [SW:0][width-1:0] data_d;
    logic [SW:0][SW-1:0]   shift_d;
    logic [SW:0][2:0]      mode_d;
    logic [SW:0]           valid_d;
    logic                  unused_tail;

    assign stall         = bus.res_valid & ~bus.res_ready;
    assign advance       = ~stall;
    assign bus.src_ready = ~stall;

    assign data_d[0]  = bus.src_bits;
    assign shift_d[0] = bus.src_shift;
    assign mode_d[0]  = bus.src_mode;
    assign valid_d[0] = bus.src_valid;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        lr_shift_stage #(
            .width (width),
            .k     (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .advance (advance),
            .data    (data_d[k]),
            .shift   (shift_d[k]),
            .mode    (mode_d[k]),
            .valid   (valid_d[k]),
            .data_q  (data_d[k+1]),
            .shift_q (shift_d[k+1]),
            .mode_q  (mode_d[k+1]),
            .valid_q (valid_d[k+1])
        );
    end

    // The last stage's mode and shift have no consumer.
    assign unused_tail = ^{shift_d[SW], mode_d[SW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res_bits  <= '0;
            bus.res_valid <= 1'b0;
        end else if (advance) begin
            bus.res_bits  <= data_d[SW];
            bus.res_valid <= valid_d[SW];
        end
    end

endmodule

// File: tb/tb_lr_shift_pipe.sv
// Directed bench for lr_shift_pipe at width 8 and width 6 with hand-computed results.
module tb_lr_shift_pipe;
    import lr_shift_pipe_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   in_idx;
    int   out_idx;
    logic rdy;

    logic [7:0] stream_exp [6] = '{8'h20, 8'h22, 8'h24, 8'h26, 8'h28, 8'h2A};

    lr_shift_pipe_if #(.width(8)) bus8 ();
    lr_shift_pipe_if #(.width(6)) bus6 ();

    lr_shift_pipe #(.width(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    lr_shift_pipe #(.width(6)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] bits, input logic [2:0] sh,
                        input shift_mode_e mode, input logic [7:0] exp);
        bus8.src_bits  = bits;
        bus8.src_shift = sh;
        bus8.src_mode  = mode;
        bus8.src_valid = 1'b1;
        #1;
        chk({tag, "_accept_ready"}, 32'(bus8.src_ready), 32'd1);
        tick();
        bus8.src_valid = 1'b0;
        tick();
        chk({tag, "_valid_t1"}, 32'(bus8.res_valid), 32'd0);
        tick();
        chk({tag, "_valid_t2"}, 32'(bus8.res_valid), 32'd0);
        tick();
        chk({tag, "_valid_t3"}, 32'(bus8.res_valid), 32'd1);
        chk({tag, "_bits"}, 32'(bus8.res_bits), 32'(exp));
        tick();
        chk({tag, "_bubble"}, 32'(bus8.res_valid), 32'd0);
    endtask

    task automatic run6(input string tag, input logic [5:0] bits, input logic [2:0] sh,
                        input shift_mode_e mode, input logic [5:0] exp);
        bus6.src_bits  = bits;
        bus6.src_shift = sh;
        bus6.src_mode  = mode;
        bus6.src_valid = 1'b1;
        tick();
        bus6.src_valid = 1'b0;
        tick();
        tick();
        tick();
        chk({tag, "_valid"}, 32'(bus6.res_valid), 32'd1);
        chk({tag, "_bits"}, 32'(bus6.res_bits), 32'(exp));
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus8.src_bits  = '0;
        bus8.src_shift = '0;
        bus8.src_mode  = SHIFT_LEFT;
        bus8.src_valid = 1'b0;
        bus8.res_ready = 1'b0;
        bus6.src_bits  = '0;
        bus6.src_shift = '0;
        bus6.src_mode  = SHIFT_LEFT;
        bus6.src_valid = 1'b0;
        bus6.res_ready = 1'b1;

        // Reset state; res_ready low so src_ready depends on res_valid being cleared.
        tick();
        tick();
        chk("rst_valid", 32'(bus8.res_valid), 32'd0);
        chk("rst_bits", 32'(bus8.res_bits), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_src_ready", 32'(bus8.src_ready), 32'd1);
        bus8.res_ready = 1'b1;

        run8("left_b1_s3", 8'hB1, 3'd3, SHIFT_LEFT, 8'h88);

        // Back-to-back arithmetic then logical right.
        bus8.src_bits  = 8'h90;
        bus8.src_shift = 3'd2;
        bus8.src_mode  = SHIFT_RIGHT_ARITH;
        bus8.src_valid = 1'b1;
        tick();
        bus8.src_mode  = SHIFT_RIGHT_LOGICAL;
        tick();
        bus8.src_valid = 1'b0;
        tick();
        tick();
        chk("b2b_first_valid", 32'(bus8.res_valid), 32'd1);
        chk("b2b_first_bits", 32'(bus8.res_bits), 32'h E4);
        tick();
        chk("b2b_second_valid", 32'(bus8.res_valid), 32'd1);
        chk("b2b_second_bits", 32'(bus8.res_bits), 32'h24);
        tick();
        chk("b2b_after_valid", 32'(bus8.res_valid), 32'd0);

        run8("rotr_81_s1", 8'h81, 3'd1, ROTATE_RIGHT, 8'hC0);
        run8("rotl_81_s4", 8'h81, 3'd4, ROTATE_LEFT, 8'h18);
        for (int m = 0; m < 5; m++) begin
            run8("s0_5a", 8'h5A, 3'd0, shift_mode_e'(m), 8'h5A);
        end

        // Six-word stream (rotate-left by 1), result side stalled in cycles 5..8.
        in_idx  = 0;
        out_idx = 0;
        for (int c = 0; c < 18; c++) begin
            rdy = !(c >= 5 && c <= 8);
            bus8.res_ready = rdy;
            if (in_idx < 6) begin
                bus8.src_valid = 1'b1;
                bus8.src_bits  = 8'h10 + in_idx[7:0];
                bus8.src_shift = 3'd1;
                bus8.src_mode  = ROTATE_LEFT;
            end else begin
                bus8.src_valid = 1'b0;
            end
            #1;
            chk("stream_src_ready", 32'(bus8.src_ready), 32'(rdy));
            if (!rdy) begin
                chk("stream_hold_valid", 32'(bus8.res_valid), 32'd1);
                chk("stream_hold_bits", 32'(bus8.res_bits),
                    32'(out_idx < 6 ? stream_exp[out_idx] : 8'h00));
            end else if (bus8.res_valid) begin
                if (out_idx < 6) begin
                    chk("stream_out_bits", 32'(bus8.res_bits), 32'(stream_exp[out_idx]));
                    out_idx++;
                end else begin
                    chk("stream_extra_valid", 32'(bus8.res_valid), 32'd0);
                end
            end
            if (bus8.src_valid && bus8.src_ready) in_idx++;
            tick();
        end
        bus8.src_valid = 1'b0;
        bus8.res_ready = 1'b1;
        chk("stream_in_count", 32'(in_idx), 32'd6);
        chk("stream_out_count", 32'(out_idx), 32'd6);

        run6("w6_rotl_s7", 6'b000001, 3'd7, ROTATE_LEFT, 6'b000010);
        run6("w6_left_s7", 6'b111111, 3'd7, SHIFT_LEFT, 6'b000000);
        run6("w6_rarith_s6", 6'b100000, 3'd6, SHIFT_RIGHT_ARITH, 6'b111111);

        // Two words in flight, then a one-cycle reset.
        bus8.src_bits  = 8'h01;
        bus8.src_shift = 3'd1;
        bus8.src_mode  = SHIFT_LEFT;
        bus8.src_valid = 1'b1;
        tick();
        bus8.src_bits  = 8'h03;
        tick();
        bus8.src_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(bus8.res_valid), 32'd0);
        chk("midrst_bits", 32'(bus8.res_bits), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_stale", 32'(bus8.res_valid), 32'd0);
        end
        run8("post_rst_rotl", 8'h96, 3'd2, ROTATE_LEFT, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
